// File: rtl/ravenoc_pkg.sv
// Shared NoC definitions: flit type encoding, field positions and the
// per-VC framing state used by the edge sink, the NI and the router.
package ravenoc_pkg;

  // Default flit geometry: type in the top two bits, pkt_size in the low bits.
  localparam int DEF_FLIT_WIDTH   = 34;
  localparam int DEF_PKT_SZ_WIDTH = 8;
  localparam int FLIT_TYPE_WIDTH  = 2;

  typedef enum logic [1:0] {
    HEAD_FLIT      = 2'b00,
    BODY_FLIT      = 2'b01,
    TAIL_FLIT      = 2'b10,
    HEAD_TAIL_FLIT = 2'b11
  } flit_type_t;

  typedef enum logic {
    VC_IDLE  = 1'b0,
    VC_DRAIN = 1'b1
  } vc_state_t;

  // A flit opens a packet when it is a head or a single-flit head_tail.
  function automatic logic is_head_flit(input flit_type_t t);
    return (t == HEAD_FLIT) || (t == HEAD_TAIL_FLIT);
  endfunction

endpackage

// File: rtl/ravenoc_edge_sink_if.sv
// Router-to-sink flit link. The router is the master (valid/flit/vc_id),
// the edge sink is the slave that returns a per-VC ready.
interface ravenoc_edge_sink_if #(
  parameter int FLIT_WIDTH  = 34,
  parameter int N_VIRT_CHN  = 2,
  parameter int VC_ID_WIDTH = 1
);
  logic                   valid;
  logic [FLIT_WIDTH-1:0]  flit;
  logic [VC_ID_WIDTH-1:0] vc_id;
  logic [N_VIRT_CHN-1:0]  ready;

  modport master (output valid, output flit, output vc_id, input ready);
  modport slave  (input valid, input flit, input vc_id, output ready);
endinterface

// File: rtl/ravenoc_edge_vc_tracker.sv
// Framing tracker for one virtual channel: follows head/body/tail order,
// counts down the flits still owed by the open packet and flags every
// framing violation with a single-cycle pulse on the accepting cycle.
module ravenoc_edge_vc_tracker
  import ravenoc_pkg::*;
#(
  parameter int PKT_SZ_WIDTH = DEF_PKT_SZ_WIDTH
) (
  input  logic                    clk_noc,
  input  logic                    arst_noc,
  input  logic                    accept_i,
  input  flit_type_t              flit_type_i,
  input  logic [PKT_SZ_WIDTH-1:0] pkt_size_i,
  output logic                    proto_err_o,
  output logic                    busy_o
);

  localparam logic [PKT_SZ_WIDTH-1:0] REM_ZERO = {PKT_SZ_WIDTH{1'b0}};
  localparam logic [PKT_SZ_WIDTH-1:0] REM_ONE  = PKT_SZ_WIDTH'(1);

  vc_state_t               state_d, state_q;
  logic [PKT_SZ_WIDTH-1:0] rem_d, rem_q;
  logic                    proto_err;

  // Next-state / remaining-flit logic; only an accepted flit moves the FSM.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    proto_err = 1'b0;
    if (accept_i) begin
      case (state_q)
        VC_IDLE: begin
          case (flit_type_i)
            HEAD_TAIL_FLIT: begin
              state_d = VC_IDLE;
            end
            HEAD_FLIT: begin
              if (pkt_size_i != REM_ZERO) begin
                state_d = VC_DRAIN;
                rem_d   = pkt_size_i;
              end else begin
                proto_err = 1'b1;
              end
            end
            BODY_FLIT, TAIL_FLIT: begin
              // Orphan continuation flit with no open packet.
              proto_err = 1'b1;
            end
            default: begin
              proto_err = 1'b1;
            end
          endcase
        end
        VC_DRAIN: begin
          case (flit_type_i)
            BODY_FLIT: begin
              if (rem_q > REM_ONE) begin
                rem_d = rem_q - REM_ONE;
              end else begin
                // Body where the tail is due: keep waiting for the tail.
                proto_err = 1'b1;
                rem_d     = REM_ONE;
              end
            end
            TAIL_FLIT: begin
              state_d   = VC_IDLE;
              rem_d     = REM_ZERO;
              proto_err = (rem_q != REM_ONE);
            end
            HEAD_FLIT: begin
              // Abandon the open packet and restart on the new head.
              proto_err = 1'b1;
              if (pkt_size_i != REM_ZERO) begin
                state_d = VC_DRAIN;
                rem_d   = pkt_size_i;
              end else begin
                state_d = VC_IDLE;
                rem_d   = REM_ZERO;
              end
            end
            HEAD_TAIL_FLIT: begin
              proto_err = 1'b1;
              state_d   = VC_IDLE;
              rem_d     = REM_ZERO;
            end
            default: begin
              proto_err = 1'b1;
            end
          endcase
        end
        default: begin
          state_d = VC_IDLE;
          rem_d   = REM_ZERO;
        end
      endcase
    end else begin
      state_d = state_q;
      rem_d   = rem_q;
    end
  end

  // FSM state and remaining-flit counter registers.
  always_ff @(posedge clk_noc or posedge arst_noc) begin
    if (arst_noc) begin
      state_q <= VC_IDLE;
      rem_q   <= REM_ZERO;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  assign proto_err_o = proto_err;
  assign busy_o      = (state_q == VC_DRAIN);

endmodule

// File: rtl/ravenoc_edge_sink.sv
// Active terminator for an unconnected mesh-edge router port. Accepts every
// flit, tracks framing per VC, keeps saturating traffic/error counters,
// captures the first misrouted head and raises a sticky IRQ.
module ravenoc_edge_sink
  import ravenoc_pkg::*;
#(
  parameter int FLIT_WIDTH   = DEF_FLIT_WIDTH,
  parameter int N_VIRT_CHN   = 2,
  parameter int VC_ID_WIDTH  = 1,
  parameter int PKT_SZ_WIDTH = DEF_PKT_SZ_WIDTH,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                   clk_noc,
  input  logic                   arst_noc,
  ravenoc_edge_sink_if.slave     fin,
  input  logic                   clear_i,
  output logic                   err_irq_o,
  output logic [CNT_WIDTH-1:0]   pkt_cnt_o,
  output logic [CNT_WIDTH-1:0]   flit_cnt_o,
  output logic [CNT_WIDTH-1:0]   proto_err_cnt_o,
  output logic [FLIT_WIDTH-1:0]  first_hdr_o,
  output logic [VC_ID_WIDTH-1:0] first_vc_o,
  output logic                   first_vld_o,
  output logic [N_VIRT_CHN-1:0]  busy_o
);

  localparam logic [CNT_WIDTH-1:0]   CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [FLIT_WIDTH-1:0]  HDR_ZERO = {FLIT_WIDTH{1'b0}};
  localparam logic [VC_ID_WIDTH-1:0] VC_ZERO  = {VC_ID_WIDTH{1'b0}};

  // Saturating +1: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c,
                                                   input logic en);
    if (en && (c != CNT_MAX)) begin
      return c + CNT_WIDTH'(1);
    end else begin
      return c;
    end
  endfunction

  logic [N_VIRT_CHN-1:0]   ready_d, ready_q, ready_gated;
  logic [N_VIRT_CHN-1:0]   vc_accept, vc_err, vc_busy;
  logic                    ready_sel, accept, is_head, proto_err;
  flit_type_t              flit_type;
  logic [PKT_SZ_WIDTH-1:0] pkt_size;

  logic [CNT_WIDTH-1:0]    pkt_cnt_d, pkt_cnt_q;
  logic [CNT_WIDTH-1:0]    flit_cnt_d, flit_cnt_q;
  logic [CNT_WIDTH-1:0]    proto_err_cnt_d, proto_err_cnt_q;
  logic [FLIT_WIDTH-1:0]   first_hdr_d, first_hdr_q;
  logic [VC_ID_WIDTH-1:0]  first_vc_d, first_vc_q;
  logic                    first_vld_d, first_vld_q;
  logic                    err_irq_d, err_irq_q;

  // Ready is held low for one cycle after reset and whenever clear is high,
  // so a clear never races an accept.
  assign ready_gated = ready_q & ~{N_VIRT_CHN{clear_i}};
  assign fin.ready   = ready_gated;

  // Decode the incoming flit and form the per-VC accept strobes; a VC id
  // outside the implemented range matches no ready bit and is never accepted.
  always_comb begin
    flit_type = flit_type_t'(fin.flit[FLIT_WIDTH-1 -: FLIT_TYPE_WIDTH]);
    pkt_size  = fin.flit[PKT_SZ_WIDTH-1:0];
    ready_sel = 1'b0;
    vc_accept = {N_VIRT_CHN{1'b0}};
    for (int v = 0; v < N_VIRT_CHN; v++) begin
      if (fin.vc_id == VC_ID_WIDTH'(v)) begin
        ready_sel = ready_gated[v];
      end else begin
        ready_sel = ready_sel;
      end
    end
    accept = fin.valid & ready_sel;
    for (int v = 0; v < N_VIRT_CHN; v++) begin
      vc_accept[v] = accept & (fin.vc_id == VC_ID_WIDTH'(v));
    end
    is_head   = is_head_flit(flit_type);
    proto_err = |vc_err;
  end

  for (genvar v = 0; v < N_VIRT_CHN; v++) begin : g_vc
    ravenoc_edge_vc_tracker #(
      .PKT_SZ_WIDTH (PKT_SZ_WIDTH)
    ) u_tracker (
      .clk_noc     (clk_noc),
      .arst_noc    (arst_noc),
      .accept_i    (vc_accept[v]),
      .flit_type_i (flit_type),
      .pkt_size_i  (pkt_size),
      .proto_err_o (vc_err[v]),
      .busy_o      (vc_busy[v])
    );
  end

  // Next values of ready, counters, first-head capture and IRQ.
  always_comb begin
    ready_d = {N_VIRT_CHN{1'b1}};
    if (clear_i) begin
      pkt_cnt_d       = CNT_ZERO;
      flit_cnt_d      = CNT_ZERO;
      proto_err_cnt_d = CNT_ZERO;
      first_hdr_d     = HDR_ZERO;
      first_vc_d      = VC_ZERO;
      first_vld_d     = 1'b0;
      err_irq_d       = 1'b0;
    end else begin
      pkt_cnt_d       = sat_inc(pkt_cnt_q, accept & is_head);
      flit_cnt_d      = sat_inc(flit_cnt_q, accept);
      proto_err_cnt_d = sat_inc(proto_err_cnt_q, proto_err);
      if (accept && is_head && !first_vld_q) begin
        first_hdr_d = fin.flit;
        first_vc_d  = fin.vc_id;
        first_vld_d = 1'b1;
      end else begin
        first_hdr_d = first_hdr_q;
        first_vc_d  = first_vc_q;
        first_vld_d = first_vld_q;
      end
      // Any flit reaching the edge is a misroute.
      err_irq_d = err_irq_q | accept;
    end
  end

  // Status and statistics registers.
  always_ff @(posedge clk_noc or posedge arst_noc) begin
    if (arst_noc) begin
      ready_q         <= {N_VIRT_CHN{1'b0}};
      pkt_cnt_q       <= CNT_ZERO;
      flit_cnt_q      <= CNT_ZERO;
      proto_err_cnt_q <= CNT_ZERO;
      first_hdr_q     <= HDR_ZERO;
      first_vc_q      <= VC_ZERO;
      first_vld_q     <= 1'b0;
      err_irq_q       <= 1'b0;
    end else begin
      ready_q         <= ready_d;
      pkt_cnt_q       <= pkt_cnt_d;
      flit_cnt_q      <= flit_cnt_d;
      proto_err_cnt_q <= proto_err_cnt_d;
      first_hdr_q     <= first_hdr_d;
      first_vc_q      <= first_vc_d;
      first_vld_q     <= first_vld_d;
      err_irq_q       <= err_irq_d;
    end
  end

  assign err_irq_o       = err_irq_q;
  assign pkt_cnt_o       = pkt_cnt_q;
  assign flit_cnt_o      = flit_cnt_q;
  assign proto_err_cnt_o = proto_err_cnt_q;
  assign first_hdr_o     = first_hdr_q;
  assign first_vc_o      = first_vc_q;
  assign first_vld_o     = first_vld_q;
  assign busy_o          = vc_busy;

endmodule

// File: tb/tb_ravenoc_edge_sink.sv
// Directed bench for ravenoc_edge_sink with a packet-level reference model
// compared against every output on every cycle, plus literal checkpoints.
module tb_ravenoc_edge_sink;
  import ravenoc_pkg::*;

  localparam int FW   = 34;
  localparam int NV   = 2;
  localparam int VW   = 1;
  localparam int PW   = 8;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk_noc = 1'b0;
  logic          arst_noc = 1'b1;
  logic          clear_i = 1'b0;
  logic          err_irq_o;
  logic [CW-1:0] pkt_cnt_o, flit_cnt_o, proto_err_cnt_o;
  logic [FW-1:0] first_hdr_o;
  logic [VW-1:0] first_vc_o;
  logic          first_vld_o;
  logic [NV-1:0] busy_o;

  ravenoc_edge_sink_if #(.FLIT_WIDTH(FW), .N_VIRT_CHN(NV), .VC_ID_WIDTH(VW)) fin_if ();

  ravenoc_edge_sink #(
    .FLIT_WIDTH(FW), .N_VIRT_CHN(NV), .VC_ID_WIDTH(VW), .PKT_SZ_WIDTH(PW), .CNT_WIDTH(CW)
  ) dut (
    .clk_noc(clk_noc), .arst_noc(arst_noc), .fin(fin_if), .clear_i(clear_i),
    .err_irq_o(err_irq_o), .pkt_cnt_o(pkt_cnt_o), .flit_cnt_o(flit_cnt_o),
    .proto_err_cnt_o(proto_err_cnt_o), .first_hdr_o(first_hdr_o),
    .first_vc_o(first_vc_o), .first_vld_o(first_vld_o), .busy_o(busy_o)
  );

  always #5 clk_noc = ~clk_noc;

  int n_pass = 0;
  int n_total = 0;
  int busy0_cnt = 0;

  // Reference model: packet-level view of the sink.
  int            m_cyc;
  int            m_pkt, m_flit, m_err;
  bit            m_irq, m_fvld;
  logic [FW-1:0] m_fhdr;
  int            m_fvc;
  bit            m_in_pkt[NV];
  int            m_rem[NV];

  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_BODY = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [7:0] sz,
                                       input logic [23:0] pl);
    return {t, pl, sz};
  endfunction

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    m_cyc = 0; m_pkt = 0; m_flit = 0; m_err = 0;
    m_irq = 1'b0; m_fvld = 1'b0; m_fhdr = '0; m_fvc = 0;
    for (int v = 0; v < NV; v++) begin
      m_in_pkt[v] = 1'b0;
      m_rem[v] = 0;
    end
  endtask

  task automatic compare_all();
    logic [NV-1:0] exp_rdy;
    logic [NV-1:0] exp_busy;
    exp_rdy = (m_cyc >= 1 && !clear_i && !arst_noc) ? 2'b11 : 2'b00;
    exp_busy = {m_in_pkt[1], m_in_pkt[0]};
    chk("ready", fin_if.ready, exp_rdy);
    chk("pkt_cnt", pkt_cnt_o, m_pkt);
    chk("flit_cnt", flit_cnt_o, m_flit);
    chk("proto_err_cnt", proto_err_cnt_o, m_err);
    chk("err_irq", err_irq_o, m_irq);
    chk("first_vld", first_vld_o, m_fvld);
    chk("first_hdr", first_hdr_o, m_fhdr);
    chk("first_vc", first_vc_o, m_fvc);
    chk("busy", busy_o, exp_busy);
  endtask

  task automatic model_edge();
    logic [1:0] t;
    int sz, vc;
    bit acc, err, hd;
    vc = int'(fin_if.vc_id);
    acc = fin_if.valid && (m_cyc >= 1) && !clear_i && (vc < NV);
    if (clear_i) begin
      m_pkt = 0; m_flit = 0; m_err = 0;
      m_irq = 1'b0; m_fvld = 1'b0; m_fhdr = '0; m_fvc = 0;
    end
    if (acc) begin
      t = fin_if.flit[FW-1:FW-2];
      sz = int'(fin_if.flit[7:0]);
      err = 1'b0;
      hd = (t == T_HEAD) || (t == T_HT);
      if (hd) begin
        if (m_in_pkt[vc]) err = 1'b1;
        m_in_pkt[vc] = 1'b0;
        if (t == T_HEAD) begin
          if (sz > 0) begin
            m_in_pkt[vc] = 1'b1;
            m_rem[vc] = sz;
          end else err = 1'b1;
        end
      end else if (t == T_BODY) begin
        if (!m_in_pkt[vc] || m_rem[vc] <= 1) err = 1'b1;
        else m_rem[vc] = m_rem[vc] - 1;
      end else begin
        if (!m_in_pkt[vc] || m_rem[vc] != 1) err = 1'b1;
        m_in_pkt[vc] = 1'b0;
      end
      m_flit = sat(m_flit + 1);
      if (hd) m_pkt = sat(m_pkt + 1);
      if (err) m_err = sat(m_err + 1);
      m_irq = 1'b1;
      if (hd && !m_fvld) begin
        m_fvld = 1'b1;
        m_fhdr = fin_if.flit;
        m_fvc = vc;
      end
    end
    if (m_cyc < 1000) m_cyc++;
  endtask

  // One clock cycle: drive, compare, advance the model, wait for next negedge.
  task automatic step(input bit v, input logic [FW-1:0] f, input int vc, input bit clr);
    fin_if.valid = v;
    fin_if.flit = f;
    fin_if.vc_id = VW'(vc);
    clear_i = clr;
    #1;
    compare_all();
    if (busy_o[0]) busy0_cnt++;
    model_edge();
    @(negedge clk_noc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 0, 1'b0);
  endtask

  task automatic do_reset();
    arst_noc = 1'b1;
    fin_if.valid = 1'b0;
    clear_i = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk_noc);
    @(negedge clk_noc);
    arst_noc = 1'b0;
  endtask

  initial begin
    fin_if.valid = 1'b0;
    fin_if.flit = '0;
    fin_if.vc_id = '0;
    @(negedge clk_noc);
    do_reset();

    // Reset release: ready low for one cycle, then all ones.
    #1;
    chk("t1_ready_first", fin_if.ready, 2'b00);
    step(1'b0, '0, 0, 1'b0);
    #1;
    chk("t1_ready_second", fin_if.ready, 2'b11);
    chk("t1_flit_cnt", flit_cnt_o, 4'd0);
    chk("t1_irq", err_irq_o, 1'b0);
    idle(1);

    // Single 4-flit packet on VC0.
    busy0_cnt = 0;
    step(1'b1, mk(T_HEAD, 8'd3, 24'h00C0DE), 0, 1'b0);
    step(1'b1, mk(T_BODY, 8'd0, 24'h000001), 0, 1'b0);
    step(1'b1, mk(T_BODY, 8'd0, 24'h000002), 0, 1'b0);
    step(1'b1, mk(T_TAIL, 8'd0, 24'h000003), 0, 1'b0);
    idle(2);
    chk("t2_busy_cycles", busy0_cnt, 3);
    chk("t2_pkt_cnt", pkt_cnt_o, 4'd1);
    chk("t2_flit_cnt", flit_cnt_o, 4'd4);
    chk("t2_err_cnt", proto_err_cnt_o, 4'd0);
    chk("t2_first_hdr", first_hdr_o, 34'h0_00C0_DE03);
    chk("t2_first_vc", first_vc_o, 1'b0);
    chk("t2_irq", err_irq_o, 1'b1);

    // Interleaved VCs.
    step(1'b0, '0, 0, 1'b1);
    step(1'b1, mk(T_HEAD, 8'd2, 24'h0000A0), 0, 1'b0);
    step(1'b1, mk(T_HT, 8'd0, 24'h0000B0), 1, 1'b0);
    step(1'b1, mk(T_BODY, 8'd0, 24'h0000A1), 0, 1'b0);
    step(1'b1, mk(T_TAIL, 8'd0, 24'h0000A2), 0, 1'b0);
    idle(1);
    chk("t3_pkt_cnt", pkt_cnt_o, 4'd2);
    chk("t3_flit_cnt", flit_cnt_o, 4'd4);
    chk("t3_err_cnt", proto_err_cnt_o, 4'd0);
    chk("t3_first_vc", first_vc_o, 1'b0);

    // Framing errors.
    step(1'b0, '0, 0, 1'b1);
    step(1'b1, mk(T_TAIL, 8'd0, 24'h000010), 1, 1'b0);
    idle(1);
    chk("t4_orphan", proto_err_cnt_o, 4'd1);
    step(1'b1, mk(T_HEAD, 8'd2, 24'h000011), 0, 1'b0);
    step(1'b1, mk(T_TAIL, 8'd0, 24'h000012), 0, 1'b0);
    idle(1);
    chk("t4_early_tail", proto_err_cnt_o, 4'd2);
    chk("t4_vc0_idle", busy_o[0], 1'b0);
    step(1'b1, mk(T_HEAD, 8'd0, 24'h000013), 0, 1'b0);
    idle(1);
    chk("t4_zero_size", proto_err_cnt_o, 4'd3);
    step(1'b1, mk(T_HEAD, 8'd2, 24'h000014), 1, 1'b0);
    step(1'b1, mk(T_HEAD, 8'd1, 24'h000015), 1, 1'b0);
    step(1'b1, mk(T_TAIL, 8'd0, 24'h000016), 1, 1'b0);
    step(1'b1, mk(T_HEAD, 8'd1, 24'h000017), 0, 1'b0);
    step(1'b1, mk(T_BODY, 8'd0, 24'h000018), 0, 1'b0);
    idle(1);
    chk("t4_body_overrun_busy", busy_o[0], 1'b1);
    step(1'b1, mk(T_TAIL, 8'd0, 24'h000019), 0, 1'b0);
    idle(1);
    chk("t4_err_total", proto_err_cnt_o, 4'd5);
    chk("t4_flit_total", flit_cnt_o, 4'd10);
    chk("t4_pkt_total", pkt_cnt_o, 4'd5);
    chk("t4_first_hdr", first_hdr_o, 34'h0_0000_1102);

    // Saturation with 4-bit counters.
    step(1'b0, '0, 0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, mk(T_HT, 8'd0, 24'(i)), 1, 1'b0);
    idle(2);
    chk("t5_flit_sat", flit_cnt_o, 4'd15);
    chk("t5_pkt_sat", pkt_cnt_o, 4'd15);

    // Clear colliding with a valid flit mid-packet.
    step(1'b0, '0, 0, 1'b1);
    step(1'b1, mk(T_HEAD, 8'd2, 24'h000020), 0, 1'b0);
    step(1'b1, mk(T_BODY, 8'd0, 24'h000021), 0, 1'b0);
    step(1'b1, mk(T_TAIL, 8'd0, 24'h000022), 0, 1'b1);
    chk("t6_flit_cleared", flit_cnt_o, 4'd0);
    chk("t6_irq_cleared", err_irq_o, 1'b0);
    chk("t6_vld_cleared", first_vld_o, 1'b0);
    chk("t6_still_busy", busy_o[0], 1'b1);
    step(1'b1, mk(T_TAIL, 8'd0, 24'h000022), 0, 1'b0);
    idle(1);
    chk("t6_flit_after", flit_cnt_o, 4'd1);
    chk("t6_err_after", proto_err_cnt_o, 4'd0);
    chk("t6_busy_after", busy_o[0], 1'b0);

    // Reset mid-packet turns the trailing body into an orphan.
    step(1'b1, mk(T_HEAD, 8'd3, 24'h000030), 0, 1'b0);
    step(1'b1, mk(T_BODY, 8'd0, 24'h000031), 0, 1'b0);
    do_reset();
    idle(1);
    step(1'b1, mk(T_BODY, 8'd0, 24'h000032), 0, 1'b0);
    idle(1);
    chk("t7_orphan_err", proto_err_cnt_o, 4'd1);
    chk("t7_flit", flit_cnt_o, 4'd1);
    chk("t7_pkt", pkt_cnt_o, 4'd0);
    chk("t7_vld", first_vld_o, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
